// File: rtl/barrel_shifter_pkg.sv
// Shared constants for the 32-bit logarithmic barrel shifter.
// Optional feature macro: BARREL_SHIFTER_ROTATE_EN (adds rotate support).
package barrel_shifter_pkg;

  // Datapath width. Only 32 is verified; must stay a power of two.
  localparam int DATA_W  = 32;
  // Shift-amount width, always log2(DATA_W).
  localparam int SHAMT_W = $clog2(DATA_W);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shift_stage.sv
// One stage of the logarithmic shifter: shifts by a fixed distance DIST when
// enabled, otherwise passes the operand through unchanged.
// Optional feature macro: BARREL_SHIFTER_ROTATE_EN (adds the rotate input).
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic              enable,
  input  logic              direction,
`ifdef BARREL_SHIFTER_ROTATE_EN
  input  logic              rotate,
`endif
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;

  // Select the shifted (or rotated) operand, then bypass when the stage is off.
  always_comb begin
    shifted = data;
    if (direction == DIR_RIGHT) begin
      shifted = data >> DIST;
    end else begin
      shifted = data << DIST;
    end
`ifdef BARREL_SHIFTER_ROTATE_EN
    // Rotation re-injects the bits that fell off the far end.
    if (rotate) begin
      if (direction == DIR_RIGHT) begin
        shifted = (data >> DIST) | (data << (DATA_W - DIST));
      end else begin
        shifted = (data << DIST) | (data >> (DATA_W - DIST));
      end
    end
`endif
    result = enable ? shifted : data;
  end

endmodule

// File: rtl/barrel_shifter32.sv
// 32-bit logarithmic barrel shifter with a registered output.
// Five cascaded stages shift by 1, 2, 4, 8 and 16, each enabled by the
// matching shift_amount bit; the chain output is captured every cycle.
// Optional feature macro: BARREL_SHIFTER_ROTATE_EN (adds the rotate port).
module barrel_shifter32
  import barrel_shifter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic               direction,
`ifdef BARREL_SHIFTER_ROTATE_EN
  input  logic               rotate,
`endif
  output logic [DATA_W-1:0]  data_out
);

  // chain[k] is the operand entering stage k; chain[SHAMT_W] is the result.
  logic [SHAMT_W:0][DATA_W-1:0] chain;

  assign chain[0] = data_in;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .DIST (1 << k)
    ) u_stage (
      .data      (chain[k]),
      .enable    (shift_amount[k]),
      .direction (direction),
`ifdef BARREL_SHIFTER_ROTATE_EN
      .rotate    (rotate),
`endif
      .result    (chain[k+1])
    );
  end

  // Output register: one-cycle latency, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else begin
      data_out <= chain[SHAMT_W];
    end
  end

endmodule

// File: tb/tb_barrel_shifter32.sv
// Self-checking bench for barrel_shifter32: directed corner cases, a full
// amount sweep in both directions, random operands, and asynchronous reset.
// Optional feature macro: BARREL_SHIFTER_ROTATE_EN (enables rotate checks).
module tb_barrel_shifter32;
  import barrel_shifter_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [DATA_W-1:0]  data_in;
  logic [SHAMT_W-1:0] shift_amount;
  logic               direction;
  logic               rotate;
  logic [DATA_W-1:0]  data_out;

  int tests_run;
  int tests_failed;

  barrel_shifter32 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .direction    (direction),
`ifdef BARREL_SHIFTER_ROTATE_EN
    .rotate       (rotate),
`endif
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain shift operators; rotation via a doubled 64-bit word.
  function automatic logic [31:0] ref_model(input logic [31:0] d, input int amt,
                                            input logic dir, input logic rot);
    logic [63:0] wide;
    logic [31:0] res;
    if (rot) begin
      wide = {d, d};
      if (dir) begin
        wide = wide >> amt;
        res  = wide[31:0];
      end else begin
        wide = wide << amt;
        res  = wide[63:32];
      end
    end else if (dir) begin
      res = d >> amt;
    end else begin
      res = d << amt;
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] expected);
    tests_run++;
    assert (data_out === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, data_out, expected);
    end
  endtask

  // Drive one operation at the falling edge, then check one cycle later.
  task automatic apply(input string tag, input logic [31:0] d, input int amt,
                       input logic dir, input logic rot);
    logic [31:0] expected;
    data_in      = d;
    shift_amount = amt[SHAMT_W-1:0];
    direction    = dir;
    rotate       = rot;
    expected     = ref_model(d, amt, dir, rot);
    @(negedge clk);
    check(tag, expected);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    data_in      = 32'hFFFF_FFFF;
    shift_amount = 5'd5;
    direction    = DIR_LEFT;
    rotate       = 1'b0;

    // Reset held across several edges: output stays cleared.
    #1;
    check("reset_initial", 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", 32'hFFFF_FFE0);

    // Back-to-back directed cases.
    apply("left_0",  32'h0000_0001, 0,  DIR_LEFT, 1'b0);
    apply("left_1",  32'h0000_0001, 1,  DIR_LEFT, 1'b0);
    apply("left_31", 32'h0000_0001, 31, DIR_LEFT, 1'b0);
    check("left_31_const", 32'h8000_0000);
    apply("right_31", 32'h8000_0000, 31, DIR_RIGHT, 1'b0);
    check("right_31_const", 32'h0000_0001);
    apply("right_4", 32'hF000_000F, 4, DIR_RIGHT, 1'b0);
    check("right_4_const", 32'h0F00_0000);
    apply("right_0", 32'hDEAD_BEEF, 0, DIR_RIGHT, 1'b0);
    check("right_0_const", 32'hDEAD_BEEF);

    // Full amount sweep in both directions.
    for (int dir = 0; dir < 2; dir++) begin
      for (int amt = 0; amt < 32; amt++) begin
        apply(dir == 0 ? "sweep_left" : "sweep_right", 32'hA5A5_A5A5, amt, dir[0], 1'b0);
      end
    end

    // Random operands, amounts and directions.
    for (int i = 0; i < 200; i++) begin
      apply("random", $urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset between edges clears the output at once.
    apply("pre_async", 32'h0000_1234, 16, DIR_LEFT, 1'b0);
    check("pre_async_const", 32'h1234_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", 32'h0);
    @(negedge clk);
    check("async_reset_held", 32'h0);
    rst_n = 1'b1;
    apply("post_async", 32'h0000_00FF, 8, DIR_LEFT, 1'b0);

`ifdef BARREL_SHIFTER_ROTATE_EN
    apply("rotl_1", 32'h8000_0001, 1, DIR_LEFT, 1'b1);
    check("rotl_1_const", 32'h0000_0003);
    apply("rotr_4", 32'h8000_0001, 4, DIR_RIGHT, 1'b1);
    check("rotr_4_const", 32'h1800_0000);
    for (int i = 0; i < 100; i++) begin
      apply("random_rot", $urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
